// File: rtl/irq_dispatch.sv
// Sixteen-source interrupt dispatcher: latches edge/level sources as pending and
// issues the highest-priority unmasked one as a single irqload pulse, gated by EOI and a holdoff.
module irq_dispatch #(
    parameter int HOLDOFF = 8,
    parameter int CNTW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] irq_src,
    input  logic [15:0] edge_sel,
    input  logic [15:0] irq_mask,
    input  logic        eoi,
    input  logic [3:0]  eoi_num,
    output logic        irqload,
    output logic [3:0]  irqnum,
    output logic        busy,
    output logic [15:0] pending,
    output logic        eoi_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_src_q;
    logic [15:0]       r_edge_q;
    logic [15:0]       r_mask_q;
    logic [15:0]       r_pending;
    logic [15:0]       w_pending_next;
    logic [15:0]       w_cand;
    logic [3:0]        r_sel;
    logic [3:0]        w_idx;
    logic              w_found;
    logic              w_take;
    logic              w_eoi_ok;
    logic [CNTW-1:0]   r_cnt;
    logic [CNTW-1:0]   w_cnt_next;
    logic              r_eoi_err;

    // Edge-set beats the issue-clear; a change of trigger mode wipes the bit.
    always_comb begin
        w_pending_next = r_pending;
        for (int n = 0; n < 16; n++) begin
            if (edge_sel[n] != r_edge_q[n]) begin
                w_pending_next[n] = 1'b0;
            end else if (edge_sel[n]) begin
                if (irq_src[n] && !r_src_q[n]) begin
                    w_pending_next[n] = 1'b1;
                end else if (r_state == S_ISSUE && r_sel == 4'(n)) begin
                    w_pending_next[n] = 1'b0;
                end
            end else begin
                w_pending_next[n] = irq_src[n];
            end
        end
    end

    assign w_cand = r_pending & ~r_mask_q;

    // Scan from the top so the lowest index overwrites last and wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int n = 15; n >= 0; n--) begin
            if (w_cand[n]) begin
                w_found = 1'b1;
                w_idx   = 4'(n);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_take     = 1'b0;
        w_eoi_ok   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = S_ISSUE;
                    w_take = 1'b1;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (eoi && eoi_num == r_sel) begin
                    w_eoi_ok = 1'b1;
                    if (HOLDOFF == 0) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next     = S_HOLD;
                        w_cnt_next = CNTW'(HOLDOFF);
                    end
                end
            end
            S_HOLD: begin
                // Last holdoff cycle: arbitrate here so the next issue follows with no idle gap.
                if (r_cnt <= CNTW'(1)) begin
                    w_cnt_next = '0;
                    if (w_found) begin
                        w_next = S_ISSUE;
                        w_take = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - CNTW'(1);
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_src_q   <= '0;
            r_edge_q  <= '0;
            r_mask_q  <= '0;
            r_pending <= '0;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_eoi_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_src_q   <= irq_src;
            r_edge_q  <= edge_sel;
            r_mask_q  <= irq_mask;
            r_pending <= w_pending_next;
            r_cnt     <= w_cnt_next;
            r_eoi_err <= eoi && !w_eoi_ok;
            if (w_take) begin
                r_sel <= w_idx;
            end
        end
    end

    // irqload decodes the state directly so an async reset drops it at once.
    assign irqload = (r_state == S_ISSUE);
    assign irqnum  = r_sel;
    assign busy    = (r_state != S_IDLE);
    assign pending = r_pending;
    assign eoi_err = r_eoi_err;

endmodule

// File: tb/tb_irq_dispatch.sv
// Self-checking bench for irq_dispatch: table of pending/eoi_err vectors plus
// issue-timing sequences scored against a queue of expected {cycle, irqnum}.
module tb_irq_dispatch;

    localparam int HOLDOFF = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] irq_src;
    logic [15:0] edge_sel;
    logic [15:0] irq_mask;
    logic        eoi;
    logic [3:0]  eoi_num;
    logic        irqload;
    logic [3:0]  irqnum;
    logic        busy;
    logic [15:0] pending;
    logic        eoi_err;

    irq_dispatch #(.HOLDOFF(HOLDOFF), .CNTW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_src  (irq_src),
        .edge_sel (edge_sel),
        .irq_mask (irq_mask),
        .eoi      (eoi),
        .eoi_num  (eoi_num),
        .irqload  (irqload),
        .irqnum   (irqnum),
        .busy     (busy),
        .pending  (pending),
        .eoi_err  (eoi_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int         cyc;
        logic [3:0] num;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [15:0] src;
        logic [15:0] edge_s;
        logic        eoi;
        logic [15:0] exp_pending;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic expect_issue(input int c, input logic [3:0] n);
        exp_t e;
        e.cyc = c;
        e.num = n;
        exp_q.push_back(e);
    endtask

    task automatic retire(input logic [3:0] n);
        eoi     = 1'b1;
        eoi_num = n;
        tick();
        eoi     = 1'b0;
    endtask

    // Scoreboard: every irqload pulse must match the next predicted issue.
    always @(negedge clk) begin
        if (!rst && irqload) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_issue: irqnum %0d at cycle %0d, none expected", irqnum, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("issue_num", 32'(irqnum), 32'(e.num));
                check("issue_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[10];
        int c, e, e2, u;

        vecs[0] = '{16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0};
        vecs[1] = '{16'hA5A5, 16'h0000, 1'b0, 16'hA5A5, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[3] = '{16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'h00F0, 16'hFFFF, 1'b0, 16'h00F0, 1'b0};
        vecs[5] = '{16'h0000, 16'hFFFF, 1'b0, 16'h00F0, 1'b0};
        vecs[6] = '{16'h0F00, 16'hFFFF, 1'b1, 16'h0FF0, 1'b1};
        vecs[7] = '{16'h0F00, 16'hFF0F, 1'b0, 16'h0F00, 1'b0};
        vecs[8] = '{16'h00F0, 16'hFF0F, 1'b0, 16'h0FF0, 1'b0};
        vecs[9] = '{16'h00F0, 16'h0000, 1'b0, 16'h00F0, 1'b0};

        rst      = 1'b1;
        irq_src  = '0;
        edge_sel = '0;
        irq_mask = 16'hFFFF;
        eoi      = 1'b0;
        eoi_num  = '0;
        tick();
        tick();
        check("rst_irqload", 32'(irqload), 0);
        check("rst_irqnum", 32'(irqnum), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_eoi_err", 32'(eoi_err), 0);
        rst = 1'b0;

        // Pending capture with every source masked, so the FSM stays idle.
        for (int i = 0; i < 10; i++) begin
            irq_src  = vecs[i].src;
            edge_sel = vecs[i].edge_s;
            eoi      = vecs[i].eoi;
            tick();
            check($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].exp_pending));
            check($sformatf("vec%0d_eoi_err", i), 32'(eoi_err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_busy", i), 32'(busy), 0);
        end
        eoi = 1'b0;

        rst      = 1'b1;
        tick();
        irq_src  = '0;
        edge_sel = 16'hFFFF;
        irq_mask = '0;
        rst      = 1'b0;
        tick();
        tick();

        // Single edge: issue two cycles after the edge, holdoff after EOI.
        c = cyc;
        irq_src[5] = 1'b1;
        expect_issue(c + 2, 4'd5);
        tick();
        check("t1_pend5", 32'(pending[5]), 1);
        check("t1_busy_pre", 32'(busy), 0);
        tick();
        check("t1_busy", 32'(busy), 1);
        tick();
        check("t1_pend5_clr", 32'(pending[5]), 0);
        irq_src = '0;
        e = cyc;
        retire(4'd5);
        wait_until(e + HOLDOFF);
        check("t1_hold_busy", 32'(busy), 1);
        tick();
        check("t1_idle", 32'(busy), 0);

        // Simultaneous edges, priority, no nesting of a higher-priority arrival.
        c = cyc;
        irq_src[3] = 1'b1;
        irq_src[9] = 1'b1;
        expect_issue(c + 2, 4'd3);
        wait_until(c + 3);
        check("t2_pending", 32'(pending), 32'h0200);
        irq_src = '0;
        e = cyc;
        expect_issue(e + HOLDOFF + 1, 4'd9);
        retire(4'd3);
        wait_until(e + HOLDOFF + 3);
        irq_src[0] = 1'b1;
        tick();
        check("t2_pend0_wait", 32'(pending[0]), 1);
        check("t2_busy_wait", 32'(busy), 1);
        irq_src = '0;
        e2 = cyc;
        expect_issue(e2 + HOLDOFF + 1, 4'd0);
        retire(4'd9);
        wait_until(e2 + HOLDOFF + 2);
        e = cyc;
        retire(4'd0);
        wait_until(e + HOLDOFF + 1);
        check("t2_idle", 32'(busy), 0);

        // Masked source stays pending; unmask issues two cycles later.
        irq_mask = 16'h0010;
        tick();
        c = cyc;
        irq_src[4] = 1'b1;
        wait_until(c + 4);
        check("t3_pend4", 32'(pending[4]), 1);
        check("t3_busy_masked", 32'(busy), 0);
        irq_src  = '0;
        u = cyc;
        irq_mask = '0;
        expect_issue(u + 2, 4'd4);
        wait_until(u + 3);
        e = cyc;
        retire(4'd4);
        wait_until(e + HOLDOFF + 1);

        // Wrong EOI in WAIT, EOI during HOLD and in IDLE.
        c = cyc;
        irq_src[7] = 1'b1;
        expect_issue(c + 2, 4'd7);
        wait_until(c + 3);
        irq_src = '0;
        retire(4'd2);
        check("t4_err_wrong", 32'(eoi_err), 1);
        check("t4_busy_wrong", 32'(busy), 1);
        tick();
        check("t4_err_clear", 32'(eoi_err), 0);
        check("t4_still_wait", 32'(busy), 1);
        e = cyc;
        retire(4'd7);
        check("t4_hold_busy", 32'(busy), 1);
        check("t4_err_good", 32'(eoi_err), 0);
        retire(4'd7);
        check("t4_err_hold", 32'(eoi_err), 1);
        wait_until(e + HOLDOFF + 1);
        check("t4_idle", 32'(busy), 0);
        retire(4'd7);
        check("t4_err_idle", 32'(eoi_err), 1);
        tick();
        check("t4_err_idle_clr", 32'(eoi_err), 0);

        // Level source: held across EOI re-issues, dropped before EOI does not.
        edge_sel = 16'hFFFD;
        tick();
        tick();
        c = cyc;
        irq_src[1] = 1'b1;
        expect_issue(c + 2, 4'd1);
        wait_until(c + 3);
        check("t5_level_pend", 32'(pending[1]), 1);
        e = cyc;
        expect_issue(e + HOLDOFF + 1, 4'd1);
        retire(4'd1);
        wait_until(e + HOLDOFF + 2);
        irq_src[1] = 1'b0;
        tick();
        tick();
        check("t5_level_drop", 32'(pending[1]), 0);
        e2 = cyc;
        retire(4'd1);
        wait_until(e2 + HOLDOFF + 4);
        check("t5_no_reissue_busy", 32'(busy), 0);
        check("t5_no_reissue_pend", 32'(pending), 0);

        // Reset asserted in the ISSUE cycle.
        edge_sel = 16'hFFFF;
        tick();
        tick();
        c = cyc;
        irq_src[6] = 1'b1;
        wait_until(c + 2);
        check("t6_irqload_pre", 32'(irqload), 1);
        check("t6_irqnum_pre", 32'(irqnum), 6);
        rst = 1'b1;
        #1;
        check("t6_irqload_rst", 32'(irqload), 0);
        check("t6_busy_rst", 32'(busy), 0);
        check("t6_irqnum_rst", 32'(irqnum), 0);
        check("t6_pending_rst", 32'(pending), 0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("t6_no_issue_busy", 32'(busy), 0);
        check("t6_no_issue_pend", 32'(pending), 0);
        irq_src[6] = 1'b0;
        tick();
        c = cyc;
        irq_src[6] = 1'b1;
        expect_issue(c + 2, 4'd6);
        wait_until(c + 3);
        irq_src = '0;
        e = cyc;
        retire(4'd6);
        wait_until(e + HOLDOFF + 2);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
